// File: rtl/key_pkg.sv
// Shared defaults and the event record for the key event scheduler.
package key_pkg;
   localparam int NBTN   = 20;
   localparam int CODE_W = 5;
   localparam int EV_W   = CODE_W + 1;

   typedef struct packed {
      logic              press;
      logic [CODE_W-1:0] code;
   } ev_t;
endpackage

// File: rtl/ev_fifo.sv
// Synchronous circular-buffer FIFO; head entry is read directly at the head pointer.
module ev_fifo #(
   parameter int WIDTH = 6,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [AW:0]      count_q, count_d;
   logic             wr, rd;

   assign empty = (count_q == '0);
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign count = count_q;
   // A push into a full buffer is legal only when the head leaves on the same edge.
   assign rd    = pop && !empty;
   assign wr    = push && (!full || rd);
   assign rdata = empty ? '0 : mem_q[head_q];

   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q + AW'(rd);
      tail_d  = tail_q + AW'(wr);
      count_d = count_q + (AW+1)'(wr) - (AW+1)'(rd);
      if (wr) mem_d[tail_q] = wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/key_event_sched.sv
// Per-key change detector that queues press/release events, lowest key first,
// into an event FIFO drained over a valid/ready handshake.
module key_event_sched #(
   parameter int NBTN   = key_pkg::NBTN,
   parameter int DEPTH  = 8,
   parameter int CODE_W = key_pkg::CODE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NBTN-1:0]   button,
   input  logic              ev_ready,
   input  logic              ovf_clr,
   output logic              ev_valid,
   output logic [CODE_W-1:0] ev_code,
   output logic              ev_press,
   output logic              irq,
   output logic              ovf
);
   import key_pkg::*;

   localparam int EW = CODE_W + 1;

   logic [NBTN-1:0]        last_q, last_d;
   logic [NBTN-1:0]        pending_q, pending_d;
   logic [NBTN-1:0]        level_q, level_d;
   logic                   ovf_q, ovf_d;
   logic [NBTN-1:0]        chg, sel_onehot, disp_mask;
   logic [CODE_W-1:0]      sel;
   logic                   sel_level, dispatch, pop;
   logic                   fifo_full, fifo_empty;
   logic [EW-1:0]          push_data, head_data;
   logic [$clog2(DEPTH):0] fifo_count;

   function automatic logic [CODE_W-1:0] lowest_set(input logic [NBTN-1:0] v);
      logic [CODE_W-1:0] r;
      r = '0;
      for (int i = NBTN - 1; i >= 0; i--)
         if (v[i]) r = CODE_W'(i);
      return r;
   endfunction

   assign chg        = button ^ last_q;
   assign sel        = lowest_set(pending_q);
   assign sel_onehot = NBTN'(1) << sel;
   assign sel_level  = |(level_q & sel_onehot);
   assign pop        = ev_valid && ev_ready;
   assign dispatch   = (|pending_q) && (!fifo_full || pop);
   assign disp_mask  = dispatch ? sel_onehot : '0;
   assign push_data  = {sel_level, sel};

   always_comb begin
      last_d    = button;
      level_d   = (level_q & ~chg) | (button & chg);
      // A fresh change wins over the clear of the key being dispatched.
      pending_d = chg | (pending_q & ~disp_mask);
      ovf_d     = ovf_q;
      if (ovf_clr) ovf_d = 1'b0;
      if (|(chg & pending_q & ~disp_mask)) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q    <= '0;
         pending_q <= '0;
         level_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         last_q    <= last_d;
         pending_q <= pending_d;
         level_q   <= level_d;
         ovf_q     <= ovf_d;
      end
   end

   ev_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (dispatch),
      .pop   (pop),
      .wdata (push_data),
      .rdata (head_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign ev_valid = !fifo_empty;
   assign irq      = ev_valid;
   assign ev_code  = head_data[CODE_W-1:0];
   assign ev_press = head_data[CODE_W];
   assign ovf      = ovf_q;
endmodule

// File: tb/tb_key_event_sched.sv
// Directed bench for key_event_sched with hand-computed expected events.
module tb_key_event_sched;
   import key_pkg::*;

   logic              clk;
   logic              rst;
   logic [NBTN-1:0]   button;
   logic              ev_ready;
   logic              ovf_clr;
   logic              ev_valid;
   logic [CODE_W-1:0] ev_code;
   logic              ev_press;
   logic              irq;
   logic              ovf;

   int n_total;
   int n_pass;

   key_event_sched #(.NBTN(NBTN), .DEPTH(8), .CODE_W(CODE_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .button   (button),
      .ev_ready (ev_ready),
      .ovf_clr  (ovf_clr),
      .ev_valid (ev_valid),
      .ev_code  (ev_code),
      .ev_press (ev_press),
      .irq      (irq),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   initial begin
      logic [9:0] exp_p4;
      logic [7:0] exp_p5;
      n_total  = 0;
      n_pass   = 0;
      rst      = 1'b0;
      button   = '0;
      ev_ready = 1'b0;
      ovf_clr  = 1'b0;
      exp_p4   = 10'b11_1111_1010;
      exp_p5   = 8'b0000_0101;

      #12;
      check("rst_valid", 32'(ev_valid), 32'd0);
      check("rst_irq",   32'(irq),      32'd0);
      check("rst_ovf",   32'(ovf),      32'd0);
      check("rst_code",  32'(ev_code),  32'd0);
      check("rst_press", 32'(ev_press), 32'd0);
      @(negedge clk) rst = 1'b1;
      repeat (5) tick();
      check("idle_valid", 32'(ev_valid), 32'd0);
      check("idle_ovf",   32'(ovf),      32'd0);

      // single press then release, consumer always ready
      ev_ready = 1'b1;
      button   = 20'h00001;
      tick();
      check("lat_k_valid", 32'(ev_valid), 32'd0);
      tick();
      check("press_valid", 32'(ev_valid), 32'd1);
      check("press_irq",   32'(irq),      32'd1);
      check("press_code",  32'(ev_code),  32'd0);
      check("press_lvl",   32'(ev_press), 32'd1);
      tick();
      check("press_gone",  32'(ev_valid), 32'd0);
      button = 20'h00000;
      tick();
      tick();
      check("rel_valid", 32'(ev_valid), 32'd1);
      check("rel_code",  32'(ev_code),  32'd0);
      check("rel_lvl",   32'(ev_press), 32'd0);
      tick();
      check("rel_gone",  32'(ev_valid), 32'd0);

      // three simultaneous presses, queued lowest index first
      ev_ready = 1'b0;
      button   = 20'h80005;
      tick();
      tick();
      check("multi_head0", 32'(ev_code), 32'd0);
      tick();
      tick();
      check("multi_hold", 32'(ev_code), 32'd0);
      ev_ready = 1'b1;
      check("multi_c0", 32'(ev_code),  32'd0);
      check("multi_p0", 32'(ev_press), 32'd1);
      tick();
      check("multi_c2", 32'(ev_code),  32'd2);
      check("multi_p2", 32'(ev_press), 32'd1);
      tick();
      check("multi_c19", 32'(ev_code),  32'd19);
      check("multi_p19", 32'(ev_press), 32'd1);
      tick();
      check("multi_empty", 32'(ev_valid), 32'd0);
      check("multi_ovf",   32'(ovf),      32'd0);

      // ten changes against an eight-deep FIFO: two wait in pending
      ev_ready = 1'b0;
      button   = 20'h803FA;
      repeat (12) tick();
      check("fill_count", 32'(dut.u_fifo.count_q), 32'd8);
      check("fill_valid", 32'(ev_valid), 32'd1);
      ev_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check($sformatf("drain_code%0d", i),  32'(ev_code),  32'(i));
         check($sformatf("drain_press%0d", i), 32'(ev_press), 32'(exp_p4[i]));
         tick();
      end
      check("drain_empty", 32'(ev_valid), 32'd0);
      check("drain_ovf",   32'(ovf),      32'd0);

      // merge on bit 12 while the FIFO is full
      ev_ready = 1'b0;
      button   = 20'h80305;
      repeat (10) tick();
      check("full_count", 32'(dut.u_fifo.count_q), 32'd8);
      button = 20'h81305;
      tick();
      check("merge_pre_ovf", 32'(ovf), 32'd0);
      button = 20'h80305;
      tick();
      check("merge_ovf", 32'(ovf), 32'd1);
      ev_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("mdrain_code%0d", i),  32'(ev_code),  32'(i));
         check($sformatf("mdrain_press%0d", i), 32'(ev_press), 32'(exp_p5[i]));
         tick();
      end
      check("merge_code",  32'(ev_code),  32'd12);
      check("merge_press", 32'(ev_press), 32'd0);
      tick();
      check("merge_empty",  32'(ev_valid), 32'd0);
      check("ovf_sticky",   32'(ovf),      32'd1);
      ovf_clr = 1'b1;
      tick();
      check("ovf_cleared", 32'(ovf), 32'd0);
      ovf_clr  = 1'b0;
      ev_ready = 1'b0;

      // asynchronous reset with events buffered
      button = 20'h00010;
      repeat (3) tick();
      check("pre_rst_valid", 32'(ev_valid), 32'd1);
      #3 rst = 1'b0;
      #1;
      check("arst_valid", 32'(ev_valid), 32'd0);
      check("arst_irq",   32'(irq),      32'd0);
      check("arst_ovf",   32'(ovf),      32'd0);
      check("arst_code",  32'(ev_code),  32'd0);
      check("arst_press", 32'(ev_press), 32'd0);
      repeat (2) tick();
      check("arst_hold", 32'(ev_valid), 32'd0);
      @(negedge clk) rst = 1'b1;
      tick();
      check("post_k_valid", 32'(ev_valid), 32'd0);
      tick();
      check("post_valid", 32'(ev_valid), 32'd1);
      check("post_code",  32'(ev_code),  32'd4);
      check("post_press", 32'(ev_press), 32'd1);
      ev_ready = 1'b1;
      tick();
      check("post_empty", 32'(ev_valid), 32'd0);
      repeat (3) tick();
      check("post_single", 32'(ev_valid), 32'd0);
      check("post_ovf",    32'(ovf),      32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/key_event_sched.md
Name: key_event_sched

Overview:
- Watches the 20 raw button/switch levels and detects per-bit changes itself.
- Schedules simultaneous changes one at a time, lowest index first, into a small event FIFO.
- Presents events to the CPU/OS side over a valid/ready handshake, with a level interrupt.
- Replaces ad-hoc whole-vector change pulses with ordered, per-key press/release events.

Parameters:
- NBTN, 20, number of button inputs.
- DEPTH, 8, event FIFO depth in entries; power of two, at least 2.
- CODE_W, 5, key code width; must satisfy 2^CODE_W >= NBTN.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- button  in  NBTN  button levels, already synchronised and debounced upstream.
- ev_ready  in  1  consumer accepts the head event this cycle.
- ovf_clr  in  1  clears the sticky overflow flag.
- ev_valid  out  1  FIFO non-empty; the head event is presented.
- ev_code  out  CODE_W  key index of the head event.
- ev_press  out  1  1 = press (new level 1), 0 = release.
- irq  out  1  level interrupt; equals ev_valid.
- ovf  out  1  sticky flag: at least one event was merged or lost.

Behaviour:
- Reset (rst=0, async) clears: last[NBTN] (last sampled levels), pending[NBTN], level[NBTN], FIFO pointers/count, ovf.
  - Consequence: outputs are ev_valid=0, irq=0, ovf=0, ev_code=0, ev_press=0.
  - Because last=0, buttons held through reset release report press events; this is intended.
- Change detect (combinational): chg = button ^ last. Every edge: last <= button.
- Pending update, per bit i, every edge:
  - If chg[i]: pending[i] <= 1 and level[i] <= button[i].
  - If chg[i] and pending[i] is already 1 and i is not being dispatched this edge:
    - ovf <= 1 (earlier transition merged).
    - The reported level is the newest one.
  - Else if i is dispatched this edge: pending[i] <= 0.
  - Set beats clear: a new change on the bit being dispatched keeps pending[i]=1, with the new level, and does not raise ovf.
- Dispatch:
  - sel = lowest index with pending[sel]=1.
  - Dispatch occurs when pending != 0 and the FIFO can accept: count < DEPTH, or a pop happens the same edge.
  - Dispatch pushes {ev_press=level[sel], ev_code=sel}. At most one push per cycle.
  - If the FIFO is full with no pop, nothing is dispatched; pending bits hold and wait with no loss.
  - ovf is raised only by merges.
- FIFO:
  - Circular buffer with head/tail pointers and a count of width log2(DEPTH)+1.
  - Pop when ev_valid && ev_ready. Push and pop in the same edge leave count unchanged, including when full.
  - Head outputs (ev_code/ev_press) come from a registered head entry or a direct buffer read at the head pointer. Either way they are stable while ev_valid=1 and ev_ready=0.
  - ev_ready while empty is ignored.
- Latency: button change settles before edge k → pending set at edge k → pushed at edge k+1 → ev_valid=1 after edge k+1. That is 2 edges with an empty FIFO and no older pending bits.
- ovf: set as above. ovf_clr=1 clears it on the next edge, but a same-edge merge wins and sets it.
- Reset mid-operation: all pending events and FIFO contents are discarded immediately; no partial handshake survives.

Decomposition:
- Shared package key_pkg holds:
  - NBTN and CODE_W defaults.
  - The event struct type {press, code} with EV_W = CODE_W+1.
- Natural sub-module: ev_fifo, a parameterised synchronous FIFO (width EV_W, depth DEPTH) with push/pop/full/empty/count and the same async active-low rst.
- The priority select (lowest set bit) is an internal function, not a module.

Test Plan:
- Reset, then button=0 steady → ev_valid=0, ovf=0 indefinitely.
- With ev_ready=1, button goes 0 → 0x00001 before edge k → ev_valid=1 after edge k+1 with code=0, press=1. Returning to 0 gives code=0, press=0.
- ev_ready=0; button goes 0 → 0x80005 in one cycle → three events in order: code 0, 2, 19, all press=1, on consecutive cycles. Then ev_ready=1 drains them in that order with ovf=0.
- ev_ready=0, DEPTH=8; toggle bits 0..9 simultaneously:
  - FIFO fills with codes 0..7 and pending holds 8, 9.
  - Raise ev_ready → codes 8, 9 follow 0..7.
  - No ovf, count never exceeds 8.
- ev_ready=0, FIFO full; bit 12 goes 0 → 1 → 0 while pending:
  - ovf=1, and a single event code=12, press=0 is delivered later.
  - ovf_clr=1 → ovf=0 on the next edge.
- Buffered events present; assert rst=0 asynchronously mid-cycle → ev_valid/irq/ovf drop to 0 immediately. With button=0x00010 held through release, a single event code=4, press=1 is delivered after release.
